booth_seq_mul: RTL and testbench

//   Multi-cycle, parametrised Booth multiplier for the CPU MUL/MULU datapath.

---
 rtl/booth_pkg.sv | 41 ++++
 rtl/booth_recode.sv | 29 ++
 rtl/booth_seq_mul.sv | 132 +++++++++++++
 tb/tb_booth_seq_mul.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared types and sizing helpers for the sequential Booth multiplier.
// BOOTH_RADIX4_EN selects radix-4 recoding (two bits retired per cycle).
package booth_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } booth_state_e;

    typedef enum logic [2:0] {
        OP_NOP,
        OP_ADD,
        OP_SUB,
        OP_ADD2,
        OP_SUB2
    } booth_op_e;

    // Two guard bits make the most negative signed and the largest unsigned
    // operand both representable as a two's complement value.
    localparam int GUARD_BITS = 2;

`ifdef BOOTH_RADIX4_EN
    localparam int DIGIT_W   = 3;
    localparam int STEP_BITS = 2;
`else
    localparam int DIGIT_W   = 2;
    localparam int STEP_BITS = 1;
`endif

    function automatic int ext_width(input int w);
        return w + GUARD_BITS;
    endfunction

    function automatic int iter_count(input int w);
        return ext_width(w) / STEP_BITS;
    endfunction

    localparam int XW = ext_width(32);

endpackage

// File: rtl/booth_recode.sv
// Booth digit recoder: maps the examined multiplier bits to an accumulator op.
// BOOTH_RADIX4_EN selects the radix-4 table, otherwise radix-2.
module booth_recode
    import booth_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    output booth_op_e          op
);

    always_comb begin
        op = OP_NOP;
`ifdef BOOTH_RADIX4_EN
        case (digit)
            3'b001, 3'b010: op = OP_ADD;
            3'b011:         op = OP_ADD2;
            3'b100:         op = OP_SUB2;
            3'b101, 3'b110: op = OP_SUB;
            default:        op = OP_NOP;
        endcase
`else
        case (digit)
            2'b01:   op = OP_ADD;
            2'b10:   op = OP_SUB;
            default: op = OP_NOP;
        endcase
`endif
    end

endmodule

// File: rtl/booth_seq_mul.sv
// Multi-cycle Booth multiplier with start/done handshake and HI/LO product outputs.
// BOOTH_RADIX4_EN switches to radix-4 steps; results are identical, latency halves.
module booth_seq_mul
    import booth_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] z_low,
    output logic [WIDTH-1:0] z_high
);

    localparam int EXT_W = ext_width(WIDTH);
    localparam int ITER  = iter_count(WIDTH);
    localparam int SUM_W = EXT_W + STEP_BITS;
    localparam int CNT_W = $clog2(ITER + 1);

    booth_state_e            state_q, state_d;
    logic signed [EXT_W-1:0] a_q, a_d;
    logic        [EXT_W-1:0] q_q, q_d;
    logic                    q1_q, q1_d;
    logic signed [EXT_W-1:0] m_q, m_d;
    logic        [CNT_W-1:0] cnt_q, cnt_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic        [WIDTH-1:0] z_low_q, z_low_d;
    logic        [WIDTH-1:0] z_high_q, z_high_d;

    booth_op_e               op;
    logic signed [SUM_W-1:0] a_ext, m_ext, addend, sum;

    booth_recode u_recode (
        .digit ({q_q[DIGIT_W-2:0], q1_q}),
        .op    (op)
    );

    // Sum is wide enough that A +/- 2M cannot overflow before the shift.
    always_comb begin
        a_ext = {{STEP_BITS{a_q[EXT_W-1]}}, a_q};
        m_ext = {{STEP_BITS{m_q[EXT_W-1]}}, m_q};
        case (op)
            OP_ADD:  addend = m_ext;
            OP_SUB:  addend = -m_ext;
            OP_ADD2: addend = m_ext <<< 1;
            OP_SUB2: addend = -(m_ext <<< 1);
            default: addend = '0;
        endcase
        sum = a_ext + addend;
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        q_d      = q_q;
        q1_d     = q1_q;
        m_d      = m_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        z_low_d  = z_low_q;
        z_high_d = z_high_q;

        case (state_q)
            S_RUN: begin
                a_d   = sum[SUM_W-1:STEP_BITS];
                q_d   = {sum[STEP_BITS-1:0], q_q[EXT_W-1:STEP_BITS]};
                q1_d  = q_q[STEP_BITS-1];
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // {A,Q} holds the exact product; keep its low 2*WIDTH bits.
                z_low_d  = q_q[WIDTH-1:0];
                z_high_d = {a_q[WIDTH-3:0], q_q[EXT_W-1:WIDTH]};
                done_d   = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (start && (state_q != S_RUN)) begin
            m_d     = {{GUARD_BITS{is_signed & multiplicand[WIDTH-1]}}, multiplicand};
            q_d     = {{GUARD_BITS{is_signed & multiplier[WIDTH-1]}}, multiplier};
            a_d     = '0;
            q1_d    = 1'b0;
            cnt_d   = CNT_W'(ITER);
            state_d = S_RUN;
        end

        busy_d = (state_d == S_RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            q_q      <= '0;
            q1_q     <= 1'b0;
            m_q      <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            z_low_q  <= '0;
            z_high_q <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            q_q      <= q_d;
            q1_q     <= q1_d;
            m_q      <= m_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            z_low_q  <= z_low_d;
            z_high_q <= z_high_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign z_low  = z_low_q;
    assign z_high = z_high_q;

endmodule

// File: tb/tb_booth_seq_mul.sv
// Randomised and directed bench for booth_seq_mul against a plain-arithmetic product model.
// Honours BOOTH_RADIX4_EN for the expected latency.
module tb_booth_seq_mul;

    localparam int W = 32;
`ifdef BOOTH_RADIX4_EN
    localparam int ITER = (W + 2) / 2;
`else
    localparam int ITER = W + 2;
`endif
    localparam int MAX_WAIT = 200;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         is_signed;
    logic [W-1:0] mcand;
    logic [W-1:0] mplier;
    logic         busy;
    logic         done;
    logic [W-1:0] z_low;
    logic [W-1:0] z_high;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    booth_seq_mul #(.WIDTH(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .is_signed    (is_signed),
        .multiplicand (mcand),
        .multiplier   (mplier),
        .busy         (busy),
        .done         (done),
        .z_low        (z_low),
        .z_high       (z_high)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Exact product of the extended operands, truncated to 2*W bits.
    function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b,
                                                input logic s);
        logic signed [2*W-1:0] ea, eb;
        ea = {{W{s & a[W-1]}}, a};
        eb = {{W{s & b[W-1]}}, b};
        return ea * eb;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        mcand     = a;
        mplier    = b;
        is_signed = s;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input int from, output int lat);
        lat = from;
        do begin
            tick();
            lat++;
        end while (!done && lat < MAX_WAIT);
    endtask

    task automatic check_result(input string tag, input logic [2*W-1:0] exp);
        chk({tag, "_lo"}, 64'(z_low), 64'(exp[W-1:0]));
        chk({tag, "_hi"}, 64'(z_high), 64'(exp[2*W-1:W]));
    endtask

    task automatic op_check(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic s);
        int lat;
        launch(a, b, s);
        wait_done(0, lat);
        chk({tag, "_lat"}, 64'(lat), 64'(ITER + 1));
        check_result(tag, ref_prod(a, b, s));
        tick();
        chk({tag, "_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        int lat;
        int seen;
        logic [W-1:0] a, b;
        logic s;
        logic [W-1:0] corners [6];
        corners = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h55555555};

        reset = 1'b1; start = 1'b0; is_signed = 1'b0; mcand = '0; mplier = '0;
        repeat (3) tick();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_zlo", 64'(z_low), 64'd0);
        chk("rst_zhi", 64'(z_high), 64'd0);
        reset = 1'b0;
        tick();

        op_check("s7xm3", 32'd7, 32'hFFFFFFFD, 1'b1);
        chk("s7xm3_k_hi", 64'(z_high), 64'hFFFFFFFF);
        chk("s7xm3_k_lo", 64'(z_low), 64'hFFFFFFEB);

        op_check("smin2", 32'h80000000, 32'h80000000, 1'b1);
        chk("smin2_k_hi", 64'(z_high), 64'h40000000);
        chk("smin2_k_lo", 64'(z_low), 64'd0);

        op_check("uones", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        chk("uones_k_hi", 64'(z_high), 64'hFFFFFFFE);
        chk("uones_k_lo", 64'(z_low), 64'd1);

        op_check("sones", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
        chk("sones_k_hi", 64'(z_high), 64'd0);
        chk("sones_k_lo", 64'(z_low), 64'd1);

        // A second start mid-operation must be ignored.
        launch(32'd100, 32'd200, 1'b0);
        repeat (3) tick();
        mcand = 32'hDEADBEEF; mplier = 32'h12345678; is_signed = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(4, lat);
        chk("ign_lat", 64'(lat), 64'(ITER + 1));
        check_result("ign", ref_prod(32'd100, 32'd200, 1'b0));
        tick();

        // start held high: operand changes during RUN are ignored, next op starts from DONE.
        mcand = 32'd5; mplier = 32'hFFFFFFF7; is_signed = 1'b1; start = 1'b1;
        tick();
        mcand = 32'h12345678; mplier = 32'h9ABCDEF0; is_signed = 1'b0;
        wait_done(0, lat);
        start = 1'b0;
        chk("b2b1_lat", 64'(lat), 64'(ITER + 1));
        check_result("b2b1", ref_prod(32'd5, 32'hFFFFFFF7, 1'b1));
        chk("b2b_busy", 64'(busy), 64'd1);
        wait_done(0, lat);
        chk("b2b2_lat", 64'(lat), 64'(ITER + 1));
        check_result("b2b2", ref_prod(32'h12345678, 32'h9ABCDEF0, 1'b0));
        tick();

        // Reset during RUN: no done pulse, outputs cleared, next op unaffected.
        launch(32'h00001234, 32'h00005678, 1'b0);
        repeat (5) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mrst_busy", 64'(busy), 64'd0);
        chk("mrst_done", 64'(done), 64'd0);
        chk("mrst_zlo", 64'(z_low), 64'd0);
        chk("mrst_zhi", 64'(z_high), 64'd0);
        seen = 0;
        for (int i = 0; i < ITER + 5; i++) begin
            tick();
            if (done) seen++;
        end
        chk("mrst_nodone", 64'(seen), 64'd0);
        op_check("postrst", 32'hFFFF0001, 32'h0000FFFF, 1'b1);

        for (int i = 0; i < 600; i++) begin
            a = $urandom();
            b = $urandom();
            s = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) a = corners[$urandom_range(0, 5)];
            if ($urandom_range(0, 7) == 0) b = corners[$urandom_range(0, 5)];
            op_check($sformatf("rnd%0d", i), a, b, s);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
